// File: rtl/mul_pipe_if.sv
`default_nettype none
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// mul_pipe_if : operand/result handshake bundle for mul_pipe
// Rev 1.0
// ----------------------------------------------------------------------------
interface mul_pipe_if #(
  parameter int WIDTH = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   dataa;
  logic [WIDTH-1:0]   datab;
  logic               signed_mode;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] result;
  logic [WIDTH-1:0]   result_lo;
  logic               overflow;
  logic [3:0]         occupancy;

  modport slave (
    input  in_valid, dataa, datab, signed_mode, out_ready,
    output in_ready, out_valid, result, result_lo, overflow, occupancy
  );

  modport master (
    output in_valid, dataa, datab, signed_mode, out_ready,
    input  in_ready, out_valid, result, result_lo, overflow, occupancy
  );
endinterface
`default_nettype wire

// File: rtl/mul_pipe.sv
`default_nettype none
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// mul_pipe : STAGES-deep signed/unsigned multiplier with valid/ready on both sides
// Rev 1.0
// ----------------------------------------------------------------------------
module mul_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 3
) (
  input  wire logic   clk,
  input  wire logic   reset_n,
  mul_pipe_if.slave   io_mul
);

  localparam int c_W2    = 2 * WIDTH;
  localparam int c_CHUNK = (c_W2 + STAGES - 1) / STAGES;
  localparam int c_LAST  = STAGES - 1;
  localparam logic [c_W2:0]   c_ONE        = {{c_W2{1'b0}}, 1'b1};
  localparam logic [c_W2-1:0] c_CHUNK_MASK = c_W2'((c_ONE << c_CHUNK) - c_ONE);

  logic [STAGES-1:0] r_v;
  logic [STAGES-1:0] r_s;
  logic [c_W2-1:0]   r_a   [STAGES];
  logic [c_W2-1:0]   r_b   [STAGES];
  logic [c_W2-1:0]   r_acc [STAGES];
  logic              r_ovf;
  logic [3:0]        r_occ;

  logic [STAGES-1:0] w_in_v;
  logic [STAGES-1:0] w_in_s;
  logic [c_W2-1:0]   w_in_a   [STAGES];
  logic [c_W2-1:0]   w_in_b   [STAGES];
  logic [c_W2-1:0]   w_in_acc [STAGES];
  logic [c_W2-1:0]   w_sum    [STAGES];
  logic [c_W2-1:0]   w_a_ext;
  logic [c_W2-1:0]   w_b_ext;
  logic [c_W2-1:0]   w_result;
  logic [WIDTH:0]    w_top;
  logic              w_ovf_nxt;
  logic              w_advance;
  logic              w_accept;
  logic              w_out_xfer;

  // Operands are widened once at entry; the low 2W bits of the product are then
  // identical for both modes, so later stages need no sign handling.
  assign w_a_ext = {{WIDTH{io_mul.signed_mode & io_mul.dataa[WIDTH-1]}}, io_mul.dataa};
  assign w_b_ext = {{WIDTH{io_mul.signed_mode & io_mul.datab[WIDTH-1]}}, io_mul.datab};

  // Stage k adds the partial product of multiplier chunk k into the running sum.
  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      if (k == 0) begin : g_head
        assign w_in_v[k]   = io_mul.in_valid;
        assign w_in_s[k]   = io_mul.signed_mode;
        assign w_in_a[k]   = w_a_ext;
        assign w_in_b[k]   = w_b_ext;
        assign w_in_acc[k] = '0;
      end else begin : g_body
        assign w_in_v[k]   = r_v[k-1];
        assign w_in_s[k]   = r_s[k-1];
        assign w_in_a[k]   = r_a[k-1];
        assign w_in_b[k]   = r_b[k-1];
        assign w_in_acc[k] = r_acc[k-1];
      end
      assign w_sum[k] = w_in_acc[k]
                      + ((w_in_a[k] * ((w_in_b[k] >> (k * c_CHUNK)) & c_CHUNK_MASK))
                         << (k * c_CHUNK));
    end
  endgenerate

  assign w_top     = w_sum[c_LAST][c_W2-1:WIDTH-1];
  assign w_ovf_nxt = w_in_s[c_LAST] ? !((w_top == '0) || (w_top == '1))
                                    : (w_top[WIDTH:1] != '0);

  assign w_advance  = !(r_v[c_LAST] && !io_mul.out_ready);
  assign w_accept   = io_mul.in_valid & w_advance;
  assign w_out_xfer = r_v[c_LAST] & io_mul.out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_v   <= '0;
      r_s   <= '0;
      r_ovf <= 1'b0;
      r_occ <= 4'd0;
      for (int k = 0; k < STAGES; k++) begin
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_acc[k] <= '0;
      end
    end else begin
      if (w_advance) begin
        r_v   <= w_in_v;
        r_s   <= w_in_s;
        r_ovf <= w_ovf_nxt;
        for (int k = 0; k < STAGES; k++) begin
          r_a[k]   <= w_in_a[k];
          r_b[k]   <= w_in_b[k];
          r_acc[k] <= w_sum[k];
        end
      end
      if (w_accept && !w_out_xfer) begin
        r_occ <= r_occ + 4'd1;
      end else if (!w_accept && w_out_xfer) begin
        r_occ <= r_occ - 4'd1;
      end
    end
  end

  // Bubble stages carry stale data, so the visible outputs are gated by valid.
  assign w_result         = r_v[c_LAST] ? r_acc[c_LAST] : '0;
  assign io_mul.in_ready  = w_advance;
  assign io_mul.out_valid = r_v[c_LAST];
  assign io_mul.result    = w_result;
  assign io_mul.result_lo = w_result[WIDTH-1:0];
  assign io_mul.overflow  = r_v[c_LAST] & r_ovf;
  assign io_mul.occupancy = r_occ;

endmodule
`default_nettype wire

// File: tb/tb_mul_pipe.sv
`default_nettype none
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_mul_pipe : scoreboard bench for mul_pipe at 32/3, 8/1 and 16/5
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_mul_pipe;

  typedef struct {
    logic [127:0] res;
    logic         ovf;
    int           acc;
    int           stall;
  } ent_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   stall32  = 0;
  int   stall8   = 0;
  int   stall16  = 0;
  int   pops32   = 0;
  ent_t q32[$];
  ent_t q8[$];
  ent_t q16[$];

  mul_pipe_if #(.WIDTH(32)) b32 ();
  mul_pipe_if #(.WIDTH(8))  b8  ();
  mul_pipe_if #(.WIDTH(16)) b16 ();

  mul_pipe #(.WIDTH(32), .STAGES(3)) u_dut32 (.clk(clk), .reset_n(reset_n), .io_mul(b32));
  mul_pipe #(.WIDTH(8),  .STAGES(1)) u_dut8  (.clk(clk), .reset_n(reset_n), .io_mul(b8));
  mul_pipe #(.WIDTH(16), .STAGES(5)) u_dut16 (.clk(clk), .reset_n(reset_n), .io_mul(b16));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: widen to 128 bits, multiply, keep 2W bits; bit 128 is overflow.
  function automatic logic [128:0] model(input logic [63:0] a, input logic [63:0] b,
                                         input logic s, input int w);
    logic [127:0] mw, m2, ae, be, p, t;
    logic ovf;
    mw = (128'd1 << w) - 128'd1;
    m2 = (128'd1 << (2 * w)) - 128'd1;
    ae = {64'd0, a} & mw;
    be = {64'd0, b} & mw;
    if (s && a[w-1]) ae = ae | ~mw;
    if (s && b[w-1]) be = be | ~mw;
    p = (ae * be) & m2;
    if (!s) begin
      ovf = (p >> w) != 128'd0;
    end else begin
      t   = p >> (w - 1);
      ovf = (t != 128'd0) && (t != (m2 >> (w - 1)));
    end
    return {ovf, p};
  endfunction

  function automatic logic [63:0] pick(input int w);
    logic [63:0] m, r;
    m = (64'd1 << w) - 64'd1;
    r = {$urandom, $urandom};
    case ($urandom_range(7))
      0:       r = 64'd0;
      1:       r = m;
      2:       r = 64'd1 << (w - 1);
      3:       r = (64'd1 << (w - 1)) - 64'd1;
      4:       r = 64'd1;
      default: r = r & m;
    endcase
    return r;
  endfunction

  // Scoreboard monitors: pop on output transfer, sampled on the falling edge.
  initial forever begin
    ent_t e;
    @(negedge clk);
    if (reset_n) begin
      n_checks++;
      if (b32.in_ready !== !(b32.out_valid && !b32.out_ready)) begin
        n_fail++; $display("FAIL in_ready32: got %b out_valid=%b out_ready=%b", b32.in_ready, b32.out_valid, b32.out_ready);
      end
      if (!b32.out_valid) begin
        n_checks++;
        if (b32.result !== 64'd0 || b32.overflow !== 1'b0) begin
          n_fail++; $display("FAIL idle_out32: result=%h overflow=%b want 0/0", b32.result, b32.overflow);
        end
      end
      if (b32.out_valid && b32.out_ready) begin
        n_checks++;
        pops32++;
        if (q32.size() == 0) begin
          n_fail++; $display("FAIL out32_unexpected: result=%h with empty scoreboard", b32.result);
        end else begin
          e = q32.pop_front();
          if (b32.result !== e.res[63:0] || b32.result_lo !== e.res[31:0] || b32.overflow !== e.ovf) begin
            n_fail++; $display("FAIL out32_data: got %h/%h/%b want %h/%h/%b", b32.result, b32.result_lo, b32.overflow, e.res[63:0], e.res[31:0], e.ovf);
          end
          if (e.stall == stall32) begin
            n_checks++;
            if (cyc != e.acc + 2) begin
              n_fail++; $display("FAIL latency32: got %0d edges want %0d", cyc - e.acc + 1, 3);
            end
          end
        end
      end
      if (b32.out_valid && !b32.out_ready) stall32++;
    end
  end

  initial forever begin
    ent_t e;
    @(negedge clk);
    if (reset_n && b8.out_valid && b8.out_ready) begin
      n_checks++;
      if (q8.size() == 0) begin
        n_fail++; $display("FAIL out8_unexpected: result=%h with empty scoreboard", b8.result);
      end else begin
        e = q8.pop_front();
        if (b8.result !== e.res[15:0] || b8.result_lo !== e.res[7:0] || b8.overflow !== e.ovf) begin
          n_fail++; $display("FAIL out8_data: got %h/%b want %h/%b", b8.result, b8.overflow, e.res[15:0], e.ovf);
        end
        if (e.stall == stall8) begin
          n_checks++;
          if (cyc != e.acc) begin
            n_fail++; $display("FAIL latency8: got %0d edges want 1", cyc - e.acc + 1);
          end
        end
      end
    end
    if (reset_n && b8.out_valid && !b8.out_ready) stall8++;
  end

  initial forever begin
    ent_t e;
    @(negedge clk);
    if (reset_n && b16.out_valid && b16.out_ready) begin
      n_checks++;
      if (q16.size() == 0) begin
        n_fail++; $display("FAIL out16_unexpected: result=%h with empty scoreboard", b16.result);
      end else begin
        e = q16.pop_front();
        if (b16.result !== e.res[31:0] || b16.result_lo !== e.res[15:0] || b16.overflow !== e.ovf) begin
          n_fail++; $display("FAIL out16_data: got %h/%b want %h/%b", b16.result, b16.overflow, e.res[31:0], e.ovf);
        end
        if (e.stall == stall16) begin
          n_checks++;
          if (cyc != e.acc + 4) begin
            n_fail++; $display("FAIL latency16: got %0d edges want 5", cyc - e.acc + 1);
          end
        end
      end
    end
    if (reset_n && b16.out_valid && !b16.out_ready) stall16++;
  end

  // In-flight count after each edge must match the scoreboard depth.
  initial forever begin
    @(posedge clk);
    #3;
    if (reset_n) begin
      n_checks++;
      if (b32.occupancy !== 4'(q32.size()) || b8.occupancy !== 4'(q8.size()) || b16.occupancy !== 4'(q16.size())) begin
        n_fail++; $display("FAIL occupancy: got %0d/%0d/%0d want %0d/%0d/%0d", b32.occupancy, b8.occupancy, b16.occupancy, q32.size(), q8.size(), q16.size());
      end
    end
  end

  task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [63:0] er, input logic eo);
    bit got = 0;
    b32.dataa = a; b32.datab = b; b32.signed_mode = s; b32.in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (b32.in_ready) begin got = 1; break; end
    end
    n_checks++;
    if (!got) begin
      n_fail++; $display("FAIL send32_timeout: in_ready stuck at %b want 1", b32.in_ready);
    end else begin
      q32.push_back('{res: {64'd0, er}, ovf: eo, acc: cyc + 1, stall: stall32});
    end
    @(posedge clk); #1;
    b32.in_valid = 1'b0;
  endtask

  task automatic drain32;
    for (int i = 0; i < 60 && q32.size() != 0; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #2;
    n_checks++; if (b32.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", b32.out_valid); end
    n_checks++; if (b32.occupancy !== 4'd0) begin n_fail++; $display("FAIL reset_occupancy: got %0d want 0", b32.occupancy); end
    n_checks++; if (b32.result !== 64'd0) begin n_fail++; $display("FAIL reset_result: got %h want 0", b32.result); end
    n_checks++; if (b32.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", b32.overflow); end
    @(negedge clk); #1;
    reset_n = 1'b1;
    #1;
    n_checks++; if (b32.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", b32.in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    b32.out_ready = 1'b1;
    send32(32'd1,   32'd2,  1'b0, 64'd2,    1'b0);
    send32(32'd332, 32'd22, 1'b0, 64'd7304, 1'b0);
    send32(32'd2,   32'd23, 1'b0, 64'd46,   1'b0);
    n_checks++; if (b32.occupancy !== 4'd3) begin n_fail++; $display("FAIL b2b_peak_occupancy: got %0d want 3", b32.occupancy); end
    n_checks++; if (b32.out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_first_valid: got %b want 1", b32.out_valid); end
    drain32();
    n_checks++; if (q32.size() != 0) begin n_fail++; $display("FAIL b2b_drain: %0d results missing want 0", q32.size()); end
  endtask

  task automatic test_corner_cases;
    b32.out_ready = 1'b1;
    send32(32'hFFFFFFFD, 32'd5,        1'b1, 64'hFFFFFFFFFFFFFFF1, 1'b0);
    send32(32'hFFFFFFFD, 32'd5,        1'b0, 64'h00000004FFFFFFF1, 1'b1);
    send32(32'h00010000, 32'h00010000, 1'b0, 64'h0000000100000000, 1'b1);
    send32(32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h0000000080000000, 1'b1);
    send32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001, 1'b1);
    send32(32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000, 1'b1);
    send32(32'h00000000, 32'hDEADBEEF, 1'b1, 64'h0000000000000000, 1'b0);
    send32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h0000000000000001, 1'b0);
    send32(32'h7FFFFFFF, 32'd2,        1'b1, 64'h00000000FFFFFFFE, 1'b1);
    drain32();
    n_checks++; if (q32.size() != 0) begin n_fail++; $display("FAIL corner_drain: %0d results missing want 0", q32.size()); end
  endtask

  task automatic test_backpressure;
    int p0;
    p0 = pops32;
    b32.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send32(32'(10 + i), 32'(100 + i), 1'b0, 64'((10 + i) * (100 + i)), 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #2;
      n_checks++; if (b32.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b want 0", b32.in_ready); end
      n_checks++; if (b32.occupancy !== 4'd3) begin n_fail++; $display("FAIL bp_occupancy: got %0d want 3", b32.occupancy); end
      n_checks++; if (b32.out_valid !== 1'b1 || b32.result !== 64'd1000) begin
        n_fail++; $display("FAIL bp_hold: got valid=%b result=%h want 1/%h", b32.out_valid, b32.result, 64'd1000);
      end
    end
    fork
      begin
        for (int i = 3; i < 6; i++) send32(32'(10 + i), 32'(100 + i), 1'b0, 64'((10 + i) * (100 + i)), 1'b0);
      end
      begin
        repeat (3) @(posedge clk);
        #1 b32.out_ready = 1'b1;
      end
    join
    drain32();
    n_checks++; if (q32.size() != 0 || pops32 - p0 != 6) begin
      n_fail++; $display("FAIL bp_release: got %0d results (%0d left) want 6", pops32 - p0, q32.size());
    end
  endtask

  task automatic test_reset_mid;
    b32.out_ready = 1'b0;
    send32(32'd3, 32'd4, 1'b0, 64'd12, 1'b0);
    send32(32'd5, 32'd6, 1'b0, 64'd30, 1'b0);
    @(posedge clk);
    @(negedge clk); #1;
    reset_n = 1'b0;
    #1;
    n_checks++; if (b32.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid: got %b want 0", b32.out_valid); end
    n_checks++; if (b32.occupancy !== 4'd0) begin n_fail++; $display("FAIL rstmid_occupancy: got %0d want 0", b32.occupancy); end
    n_checks++; if (b32.result !== 64'd0) begin n_fail++; $display("FAIL rstmid_result: got %h want 0", b32.result); end
    q32.delete();
    #1;
    reset_n = 1'b1;
    b32.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #2;
      n_checks++; if (b32.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_stale: got out_valid=%b result=%h want 0", b32.out_valid, b32.result); end
    end
    send32(32'd7, 32'd6, 1'b0, 64'd42, 1'b0);
    drain32();
    n_checks++; if (q32.size() != 0) begin n_fail++; $display("FAIL rstmid_drain: %0d results missing want 0", q32.size()); end
  endtask

  task automatic test_param_sweep;
    int sent8 = 0;
    int sent16 = 0;
    logic [128:0] m;
    for (int t = 0; t < 30000; t++) begin
      @(posedge clk); #1;
      b8.out_ready  = ($urandom_range(3) != 0);
      b16.out_ready = ($urandom_range(3) != 0);
      if (sent8 < 1000 && $urandom_range(3) != 0) begin
        b8.in_valid = 1'b1; b8.dataa = 8'(pick(8)); b8.datab = 8'(pick(8)); b8.signed_mode = 1'($urandom_range(1));
      end else begin
        b8.in_valid = 1'b0;
      end
      if (sent16 < 1000 && $urandom_range(3) != 0) begin
        b16.in_valid = 1'b1; b16.dataa = 16'(pick(16)); b16.datab = 16'(pick(16)); b16.signed_mode = 1'($urandom_range(1));
      end else begin
        b16.in_valid = 1'b0;
      end
      @(negedge clk);
      if (b8.in_valid && b8.in_ready) begin
        m = model({56'd0, b8.dataa}, {56'd0, b8.datab}, b8.signed_mode, 8);
        q8.push_back('{res: m[127:0], ovf: m[128], acc: cyc + 1, stall: stall8});
        sent8++;
      end
      if (b16.in_valid && b16.in_ready) begin
        m = model({48'd0, b16.dataa}, {48'd0, b16.datab}, b16.signed_mode, 16);
        q16.push_back('{res: m[127:0], ovf: m[128], acc: cyc + 1, stall: stall16});
        sent16++;
      end
      if (sent8 >= 1000 && sent16 >= 1000 && q8.size() == 0 && q16.size() == 0) break;
    end
    b8.in_valid = 1'b0;  b8.out_ready = 1'b1;
    b16.in_valid = 1'b0; b16.out_ready = 1'b1;
    n_checks++; if (sent8 < 1000 || q8.size() != 0) begin n_fail++; $display("FAIL sweep8_done: sent %0d left %0d want 1000/0", sent8, q8.size()); end
    n_checks++; if (sent16 < 1000 || q16.size() != 0) begin n_fail++; $display("FAIL sweep16_done: sent %0d left %0d want 1000/0", sent16, q16.size()); end
  endtask

  initial begin
    b32.in_valid = 1'b0; b32.dataa = '0; b32.datab = '0; b32.signed_mode = 1'b0; b32.out_ready = 1'b1;
    b8.in_valid  = 1'b0; b8.dataa  = '0; b8.datab  = '0; b8.signed_mode  = 1'b0; b8.out_ready  = 1'b1;
    b16.in_valid = 1'b0; b16.dataa = '0; b16.datab = '0; b16.signed_mode = 1'b0; b16.out_ready = 1'b1;
    test_reset();
    test_back_to_back();
    test_corner_cases();
    test_backpressure();
    test_reset_mid();
    test_param_sweep();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
